spike_aer_arbiter: RTL and testbench

- Parametrised successor to the fixed 8-input spike output controller.
- Arbitrates N_CH neuron spike requests and acknowledges exactly one per cycle, using round-robin or fixed-LSB priority.
- Encodes the winner as an address-event (AER) word and buffers it in a small FIFO.
- Presents events downstream on a valid/ready interface; sits between a neuron layer and the inter-layer/off-chip AER link.

---
 rtl/spike_aer_pkg.sv | 16 +
 rtl/spike_aer_arbiter_if.sv | 31 +++
 rtl/spike_aer_arbiter_rr_arbiter.sv | 31 +++
 rtl/spike_aer_arbiter.sv | 72 +++++++
 tb/tb_spike_aer_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/spike_aer_pkg.sv
// spike_aer_pkg: shared constants and types for the AER spike arbiter.
// The event entry carries a timestamp only when AER_TIMESTAMP_EN is defined.
package spike_aer_pkg;
    localparam int N_CH_DEF       = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TS_W           = 16;
    localparam int DROP_W         = 16;
    typedef logic [TS_W-1:0]   ts_t;
    typedef logic [DROP_W-1:0] drop_t;
    typedef struct packed {
`ifdef AER_TIMESTAMP_EN
        ts_t                         ts;
`endif
        logic [$clog2(N_CH_DEF)-1:0] addr;
    } aer_event_t;
endpackage

// File: rtl/spike_aer_arbiter_if.sv
// spike_aer_arbiter_if: spike request/ack lines plus the AER valid/ready output.
// The aer_ts signal exists only with AER_TIMESTAMP_EN.
interface spike_aer_arbiter_if import spike_aer_pkg::*; #(
    parameter int N_CH   = N_CH_DEF,
    parameter int ADDR_W = $clog2(N_CH)
);
    logic [N_CH-1:0]   spikes_in;
    logic [N_CH-1:0]   acks_out;
    logic              aer_valid;
    logic [ADDR_W-1:0] aer_addr;
    logic              aer_ready;
    logic              fifo_full;
    drop_t             drop_cnt;
`ifdef AER_TIMESTAMP_EN
    ts_t               aer_ts;
`endif
    modport master (
        input  spikes_in, aer_ready,
        output acks_out, aer_valid, aer_addr, fifo_full, drop_cnt
`ifdef AER_TIMESTAMP_EN
        , output aer_ts
`endif
    );
    modport slave (
        output spikes_in, aer_ready,
        input  acks_out, aer_valid, aer_addr, fifo_full, drop_cnt
`ifdef AER_TIMESTAMP_EN
        , input aer_ts
`endif
    );
endinterface

// File: rtl/spike_aer_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant over req_i, searching from ptr_i (RR_MODE=1)
// or from index 0 (RR_MODE=0, lowest index wins).
module rr_arbiter #(
    parameter int N_CH    = 8,
    parameter int ADDR_W  = $clog2(N_CH),
    parameter bit RR_MODE = 1'b1
) (
    input  logic [N_CH-1:0]   req_i,
    input  logic [ADDR_W-1:0] ptr_i,
    output logic [N_CH-1:0]   gnt_o,
    output logic [ADDR_W-1:0] idx_o
);
    localparam logic [ADDR_W:0] NC = (ADDR_W+1)'(N_CH);
    logic [ADDR_W:0] s;
    logic            found;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        s     = '0;
        for (int i = 0; i < N_CH; i++) begin
            s = (RR_MODE ? {1'b0, ptr_i} : '0) + (ADDR_W+1)'(i);
            s = s >= NC ? s - NC : s;
            if (!found && req_i[s[ADDR_W-1:0]]) begin
                found                  = 1'b1;
                gnt_o[s[ADDR_W-1:0]]   = 1'b1;
                idx_o                  = s[ADDR_W-1:0];
            end
        end
    end
endmodule

// File: rtl/spike_aer_arbiter.sv
// spike_aer_arbiter: arbitrates spike requests, encodes the winner as an AER
// event and buffers it in a small FIFO. AER_TIMESTAMP_EN adds per-event timestamps.
module spike_aer_arbiter import spike_aer_pkg::*; #(
    parameter int N_CH       = N_CH_DEF,
    parameter int ADDR_W     = $clog2(N_CH),
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter bit RR_MODE    = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    spike_aer_arbiter_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef struct packed {
`ifdef AER_TIMESTAMP_EN
        ts_t               ts;
`endif
        logic [ADDR_W-1:0] addr;
    } entry_t;
    entry_t            mem_q [FIFO_DEPTH];
    entry_t            wr_ent;
    logic [PW:0]       wr_q, rd_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d, idx;
    logic [N_CH-1:0]   gnt;
    drop_t             drop_q;
    logic              empty, full, push, pop;
    rr_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .RR_MODE(RR_MODE)) u_arb (
        .req_i(bus.spikes_in),
        .ptr_i(ptr_q),
        .gnt_o(gnt),
        .idx_o(idx)
    );
    assign empty = wr_q == rd_q;
    assign full  = wr_q == {~rd_q[PW], rd_q[PW-1:0]};
    assign push  = |bus.spikes_in && !full;
    assign pop   = !empty && bus.aer_ready;
    assign ptr_d = idx == ADDR_W'(N_CH-1) ? '0 : idx + 1'b1;
    // gating with rst_n drops acks the instant reset asserts
    assign bus.acks_out  = (rst_n && push) ? gnt : '0;
    assign bus.aer_valid = !empty;
    assign bus.aer_addr  = mem_q[rd_q[PW-1:0]].addr;
    assign bus.fifo_full = full;
    assign bus.drop_cnt  = drop_q;
`ifdef AER_TIMESTAMP_EN
    ts_t ts_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + 1'b1;
    end
    assign wr_ent     = '{ts: ts_q, addr: idx};
    assign bus.aer_ts = mem_q[rd_q[PW-1:0]].ts;
`else
    assign wr_ent = '{addr: idx};
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            ptr_q  <= '0;
            drop_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q[PW-1:0]] <= wr_ent;
                wr_q                <= wr_q + 1'b1;
                if (RR_MODE) ptr_q  <= ptr_d;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            if (full && |bus.spikes_in && drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_spike_aer_arbiter.sv
// tb_spike_aer_arbiter: fixed-priority and round-robin instances driven side by side,
// each checked against its own arbiter/FIFO model and an expected-event queue.
module tb_spike_aer_arbiter;
    import spike_aer_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ready = 1'b0;
    logic [7:0] spk [2];
    always #5 clk = ~clk;
    spike_aer_arbiter_if #(.N_CH(8)) bus0 ();
    spike_aer_arbiter_if #(.N_CH(8)) bus1 ();
    assign bus0.spikes_in = spk[0];
    assign bus1.spikes_in = spk[1];
    assign bus0.aer_ready = ready;
    assign bus1.aer_ready = ready;
    spike_aer_arbiter #(.N_CH(8), .FIFO_DEPTH(4), .RR_MODE(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    spike_aer_arbiter #(.N_CH(8), .FIFO_DEPTH(4), .RR_MODE(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    logic [7:0]  ack_w  [2];
    logic        val_w  [2];
    logic [2:0]  addr_w [2];
    logic        full_w [2];
    logic [15:0] drop_w [2];
    assign ack_w[0]  = bus0.acks_out;  assign ack_w[1]  = bus1.acks_out;
    assign val_w[0]  = bus0.aer_valid; assign val_w[1]  = bus1.aer_valid;
    assign addr_w[0] = bus0.aer_addr;  assign addr_w[1] = bus1.aer_addr;
    assign full_w[0] = bus0.fifo_full; assign full_w[1] = bus1.fifo_full;
    assign drop_w[0] = bus0.drop_cnt;  assign drop_w[1] = bus1.drop_cnt;
`ifdef AER_TIMESTAMP_EN
    logic [15:0] ts_w [2];
    assign ts_w[0] = bus0.aer_ts; assign ts_w[1] = bus1.aer_ts;
    int tsq_m [2][$];
`endif
    int q_m [2][$];
    int ptr_m [2];
    int drop_m [2];
    int ts_m;
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int winner(input logic [7:0] r, input int start);
        logic [2:0] k;
        for (int i = 0; i < 8; i++) begin
            k = 3'(start + i);
            if (r[k]) return int'(k);
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            q_m[m].delete();
`ifdef AER_TIMESTAMP_EN
            tsq_m[m].delete();
`endif
            ptr_m[m]  = 0;
            drop_m[m] = 0;
        end
        ts_m = 0;
    endtask

    // called at a falling edge; checks this cycle, advances the model past the next rising edge
    task automatic step(input bit consume, input logic rdy);
        int w [2];
        logic [7:0] ea [2];
        int sz;
        ready = rdy;
        #1;
        for (int m = 0; m < 2; m++) begin
            sz    = q_m[m].size();
            w[m]  = (spk[m] != 8'h00 && sz < 4) ? winner(spk[m], m == 1 ? ptr_m[m] : 0) : -1;
            ea[m] = w[m] >= 0 ? 8'(1 << w[m]) : 8'h00;
            check($sformatf("m%0d.ack", m), 32'(ack_w[m]), 32'(ea[m]));
            check($sformatf("m%0d.valid", m), 32'(val_w[m]), 32'(sz > 0));
            check($sformatf("m%0d.full", m), 32'(full_w[m]), 32'(sz == 4));
            check($sformatf("m%0d.drop", m), 32'(drop_w[m]), 32'(drop_m[m]));
            if (sz > 0) begin
                check($sformatf("m%0d.addr", m), 32'(addr_w[m]), 32'(q_m[m][0]));
`ifdef AER_TIMESTAMP_EN
                check($sformatf("m%0d.ts", m), 32'(ts_w[m]), 32'(tsq_m[m][0]));
`endif
            end
            if (sz == 4 && spk[m] != 8'h00 && drop_m[m] < 65535) drop_m[m]++;
            if (sz > 0 && rdy) begin
                void'(q_m[m].pop_front());
`ifdef AER_TIMESTAMP_EN
                void'(tsq_m[m].pop_front());
`endif
            end
            if (w[m] >= 0) begin
                q_m[m].push_back(w[m]);
`ifdef AER_TIMESTAMP_EN
                tsq_m[m].push_back(ts_m);
`endif
                ptr_m[m] = (w[m] + 1) % 8;
            end
        end
        ts_m = (ts_m + 1) & 16'hFFFF;
        @(negedge clk);
        if (consume) for (int m = 0; m < 2; m++) spk[m] &= ~ea[m];
    endtask

    task automatic set_spk(input logic [7:0] p);
        spk[0] = p;
        spk[1] = p;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d.rst_valid", m), 32'(val_w[m]), 32'd0);
            check($sformatf("m%0d.rst_ack", m), 32'(ack_w[m]), 32'd0);
            check($sformatf("m%0d.rst_drop", m), 32'(drop_w[m]), 32'd0);
            check($sformatf("m%0d.rst_full", m), 32'(full_w[m]), 32'd0);
            check($sformatf("m%0d.rst_addr", m), 32'(addr_w[m]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        set_spk(8'h00);
        model_clear();
        @(negedge clk);
        do_reset();
        set_spk(8'b0010_1100);
        repeat (4) step(1'b1, 1'b1);
        set_spk(8'h00);
        repeat (2) step(1'b0, 1'b1);
        do_reset();
        set_spk(8'hFF);
        repeat (10) step(1'b0, 1'b1);
        set_spk(8'h00);
        repeat (3) step(1'b0, 1'b1);
        set_spk(8'h01);
        repeat (7) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        set_spk(8'h00);
        repeat (6) step(1'b0, 1'b1);
        set_spk(8'hFF);
        repeat (3) step(1'b0, 1'b0);
        do_reset();
        repeat (3) step(1'b0, 1'b1);
        set_spk(8'h00);
        repeat (4) step(1'b0, 1'b1);
`ifdef AER_TIMESTAMP_EN
        set_spk(8'h01);
        step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1);
        set_spk(8'h01);
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        ready = 1'b1;
        repeat (65530) begin
            @(negedge clk);
            ts_m = (ts_m + 1) & 16'hFFFF;
        end
        set_spk(8'hFF);
        repeat (8) step(1'b0, 1'b1);
        set_spk(8'h00);
        repeat (4) step(1'b0, 1'b1);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
